branch_predictor: RTL

Parametrised dynamic branch predictor for the MIPS pipeline: a direct-mapped branch target buffer with per-entry saturating direction counters. It is looked up combinationally with the IF-stage PC to steer the next fetch address. It is trained by branch/jump resolution in ID, replacing the fixed predict-not-taken-and-flush behaviour. Optional performance counters track resolved branches and mispredictions.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 114 +++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// IF/ID-side signal bundle for the branch predictor: fetch lookup, ID-stage training and stats.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  // Pipeline side.
  modport master (
    output if_pc, stall, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
           upd_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, stat_branches, stat_mispred
  );

  // Predictor side.
  modport slave (
    input  if_pc, stall, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
           upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, looked up combinationally from IF.
// Define BP_STATS_EN to build the resolved-branch / misprediction counters.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2
) (
  input logic              clk,
  input logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  localparam logic [CNT_W-1:0] CTR_WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CTR_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CTR_MAX = '1;
  localparam logic [CNT_W-1:0] CTR_MIN = '0;
  localparam logic [CNT_W-1:0] CTR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [29:0]      target_q [ENTRIES];
  logic [CNT_W-1:0] ctr_q    [ENTRIES];

  // Lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx = bp.if_pc[IDX_W+1:2];
  assign lk_tag = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];

  always_comb begin
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][CNT_W-1];
  end

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? {target_q[lk_idx], 2'b00} : bp.if_pc + 32'd4;

  // Training
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             accept;
  logic [CNT_W-1:0] upd_ctr_d;

  assign upd_idx = bp.upd_pc[IDX_W+1:2];
  assign upd_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign accept  = bp.upd_valid && !bp.stall;

  assign bp.mispredict = accept &&
      ((bp.upd_taken != bp.upd_pred_taken) ||
       (bp.upd_taken && bp.upd_pred_taken && (bp.upd_target != bp.upd_pred_target)));

  always_comb begin
    upd_ctr_d = ctr_q[upd_idx];
    if (bp.upd_taken) begin
      if (upd_ctr_d != CTR_MAX) upd_ctr_d = upd_ctr_d + CTR_ONE;
    end else if (upd_ctr_d != CTR_MIN) begin
      upd_ctr_d = upd_ctr_d - CTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (accept) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_d;
        if (bp.upd_taken) target_q[upd_idx] <= bp.upd_target[31:2];
      end else if (bp.upd_taken) begin
        // Taken miss allocates over whatever lived at this index.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bp.upd_target[31:2];
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (accept) begin
      if (branches_q != '1) branches_q <= branches_q + 32'd1;
      if (bp.mispredict && (mispred_q != '1)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign bp.stat_branches = branches_q;
  assign bp.stat_mispred  = mispred_q;
`else
  assign bp.stat_branches = 32'd0;
  assign bp.stat_mispred  = 32'd0;
`endif

  // PC bits outside index/tag and target alignment bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bp.if_pc, bp.upd_pc, bp.upd_target[1:0]};
endmodule
